// File: rtl/serial_frame_decoder.sv
// Serial frame decoder: header match, fixed-length payload,
// optional additive checksum and inter-byte timeout.
module serial_frame_decoder #(
  parameter int NUM_TYPES = 2,
  parameter int HDR_LEN = 5,
  parameter logic [NUM_TYPES*HDR_LEN*8-1:0] HEADERS =
    {"ABCDE", "FGHIJ"},
  parameter logic [NUM_TYPES*16-1:0] PAYLOAD_LENS =
    {16'd16, 16'd8},
  parameter bit CHECKSUM_EN = 1'b1,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int TW =
    (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_data_ready,
  output logic [7:0]    msg_out,
  output logic          data_valid,
  output logic [TW-1:0] msg_type,
  output logic          frame_active,
  output logic          frame_done,
  output logic          frame_error,
  output logic [1:0]    error_code
);

  localparam int IW = $clog2(HDR_LEN + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, HEADER, PAYLOAD, CHECK
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_TYPES-1:0] mask_q, mask_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [7:0]           csum_q, csum_d;
  logic [TOW-1:0]       tcnt_q, tcnt_d;
  logic [7:0]           msg_out_q, msg_out_d;
  logic [TW-1:0]        msg_type_q, msg_type_d;
  logic [1:0]           err_q, err_d;
  logic                 active_q, active_d;
  logic                 dv_q, dv_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  logic [NUM_TYPES-1:0] m0, mi, hdr_mask;
  logic [IW-1:0]        hdr_next;
  logic                 hdr_go, tmo;
  logic [TW-1:0]        ty;
  logic [15:0]          len;

  function automatic logic [NUM_TYPES-1:0] hdr_match(
    input logic [7:0] b,
    input int         pos
  );
    logic [NUM_TYPES-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_TYPES; k++)
      m[k] = (HEADERS[(k+1)*HDR_LEN*8-1-pos*8 -: 8] == b);
    return m;
  endfunction

  function automatic logic [TW-1:0] low_bit(
    input logic [NUM_TYPES-1:0] m
  );
    logic [TW-1:0] r;
    r = '0;
    for (int k = NUM_TYPES - 1; k >= 0; k--)
      if (m[k]) r = TW'(k);
    return r;
  endfunction

  assign tmo = (state_q != IDLE) && !rx_data_ready &&
               (tcnt_q == TOW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    tcnt_d     = tcnt_q;
    msg_out_d  = msg_out_q;
    msg_type_d = msg_type_q;
    err_d      = err_q;
    active_d   = active_q;
    dv_d       = 1'b0;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    hdr_go     = 1'b0;
    hdr_mask   = '0;
    hdr_next   = '0;
    ty         = '0;
    len        = '0;
    m0 = hdr_match(rx_data, 0);
    mi = mask_q & hdr_match(rx_data, int'(idx_q));
    if (state_q != IDLE) tcnt_d = tcnt_q + TOW'(1);
    if (rx_data_ready) tcnt_d = '0;
    if (tmo) begin
      state_d  = IDLE;
      ferr_d   = 1'b1;
      err_d    = 2'd2;
      active_d = 1'b0;
    end else if (rx_data_ready) begin
      unique case (state_q)
        IDLE: begin
          hdr_go   = 1'b1;
          hdr_mask = m0;
          hdr_next = IW'(1);
        end
        HEADER: begin
          hdr_go = 1'b1;
          if (mi != '0) begin
            hdr_mask = mi;
            hdr_next = idx_q + IW'(1);
          end else begin
            // dead candidate: re-test this byte as a new header start
            hdr_mask = m0;
            hdr_next = IW'(1);
          end
        end
        PAYLOAD: begin
          msg_out_d = rx_data;
          dv_d      = 1'b1;
          csum_d    = csum_q + rx_data;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            if (CHECKSUM_EN) begin
              state_d = CHECK;
            end else begin
              state_d  = IDLE;
              done_d   = 1'b1;
              active_d = 1'b0;
            end
          end
        end
        CHECK: begin
          state_d  = IDLE;
          active_d = 1'b0;
          if (rx_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
            err_d  = 2'd1;
          end
        end
        default: ;
      endcase
    end
    if (hdr_go) begin
      mask_d  = hdr_mask;
      idx_d   = hdr_next;
      state_d = HEADER;
      if (hdr_mask == '0) begin
        state_d = IDLE;
      end else if (hdr_next == IW'(HDR_LEN)) begin
        ty         = low_bit(hdr_mask);
        len        = PAYLOAD_LENS[int'(ty)*16 +: 16];
        msg_type_d = ty;
        cnt_d      = len;
        csum_d     = '0;
        mask_d     = '0;
        idx_d      = '0;
        if (len != 16'd0) begin
          state_d  = PAYLOAD;
          active_d = 1'b1;
        end else if (CHECKSUM_EN) begin
          state_d  = CHECK;
          active_d = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
    if (state_d == IDLE) begin
      tcnt_d = '0;
      mask_d = '0;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      csum_q     <= '0;
      tcnt_q     <= '0;
      msg_out_q  <= '0;
      msg_type_q <= '0;
      err_q      <= '0;
      active_q   <= 1'b0;
      dv_q       <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      tcnt_q     <= tcnt_d;
      msg_out_q  <= msg_out_d;
      msg_type_q <= msg_type_d;
      err_q      <= err_d;
      active_q   <= active_d;
      dv_q       <= dv_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign msg_out      = msg_out_q;
  assign data_valid   = dv_q;
  assign msg_type     = msg_type_q;
  assign frame_active = active_q;
  assign frame_done   = done_q;
  assign frame_error  = ferr_q;
  assign error_code   = err_q;

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Scoreboard bench for serial_frame_decoder: expected bytes and
// frame-end events are queued at drive time and popped on output.
module tb_serial_frame_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_ready = 1'b0;
  logic [7:0] msg_out;
  logic       data_valid;
  logic [0:0] msg_type;
  logic       frame_active;
  logic       frame_done;
  logic       frame_error;
  logic [1:0] error_code;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   dv_count = 0;

  serial_frame_decoder #(
    .NUM_TYPES(2),
    .HDR_LEN(2),
    .HEADERS({"AC", "AB"}),
    .PAYLOAD_LENS({16'd1, 16'd3}),
    .CHECKSUM_EN(1'b1),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_data_ready(rx_data_ready),
    .msg_out(msg_out),
    .data_valid(data_valid),
    .msg_type(msg_type),
    .frame_active(frame_active),
    .frame_done(frame_done),
    .frame_error(frame_error),
    .error_code(error_code)
  );

  always #5 clk = ~clk;

  // kind 0 = payload byte, 1 = frame_done (val=type), 2 = frame_error (val=code)
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_count++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_byte got unexpected %02h", msg_out);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== 2'd0 || msg_out !== e.val) begin
          fails++;
          $display("FAIL sb_byte got %02h want kind%0d %02h",
                   msg_out, e.kind, e.val);
        end
      end
    end
    if (frame_done === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_done got unexpected done type %0d",
                 msg_type);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== 2'd1 || {7'd0, msg_type} !== e.val) begin
          fails++;
          $display("FAIL sb_done got done type %0d want kind%0d %0d",
                   msg_type, e.kind, e.val);
        end
      end
    end
    if (frame_error === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_error got unexpected error code %0d",
                 error_code);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== 2'd2 || {6'd0, error_code} !== e.val) begin
          fails++;
          $display("FAIL sb_error got code %0d want kind%0d %0d",
                   error_code, e.kind, e.val);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] v);
    exp_t x;
    x.kind = k;
    x.val = v;
    exp_q.push_back(x);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx_data = "A";
    rx_data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
    tests++;
    if ({msg_out, data_valid, msg_type, frame_done,
         frame_error, error_code} !== 14'd0) begin
      fails++;
      $display("FAIL reset_outputs got %02h %b %b %b %b %0d want 0",
               msg_out, data_valid, msg_type, frame_done,
               frame_error, error_code);
    end
    tests++;
    if (frame_active !== 1'b0) begin
      fails++;
      $display("FAIL reset_active got %b want 0", frame_active);
    end
    reset = 1'b0;
    send("B");
    idle(2);
    tests++;
    if (frame_active !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_frame got active %b want 0",
               frame_active);
    end
  endtask

  task automatic test_basic;
    dv_count = 0;
    send("A");
    send("B");
    tests++;
    if (frame_active !== 1'b1 || msg_type !== 1'b0) begin
      fails++;
      $display("FAIL basic_hdr got active %b type %0d want 1 0",
               frame_active, msg_type);
    end
    push(2'd0, 8'h01); send(8'h01);
    push(2'd0, 8'h02); send(8'h02);
    push(2'd0, 8'h03); send(8'h03);
    push(2'd1, 8'd0);  send(8'h06);
    tests++;
    if (frame_active !== 1'b0) begin
      fails++;
      $display("FAIL basic_active_drop got %b want 0", frame_active);
    end
    idle(3);
    tests++;
    if (dv_count !== 3) begin
      fails++;
      $display("FAIL basic_dv_count got %0d want 3", dv_count);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL basic_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_checksum_err;
    send("A");
    send("C");
    tests++;
    if (msg_type !== 1'b1) begin
      fails++;
      $display("FAIL cks_type got %0d want 1", msg_type);
    end
    push(2'd0, 8'hFF); send(8'hFF);
    push(2'd2, 8'd1);  send(8'hFE);
    idle(3);
    tests++;
    if (msg_out !== 8'hFF || error_code !== 2'd1) begin
      fails++;
      $display("FAIL cks_hold got %02h code %0d want FF 1",
               msg_out, error_code);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL cks_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_resync;
    send("A");
    send("A");
    send("B");
    tests++;
    if (frame_active !== 1'b1 || msg_type !== 1'b0) begin
      fails++;
      $display("FAIL resync_hdr got active %b type %0d want 1 0",
               frame_active, msg_type);
    end
    push(2'd0, 8'h10); send(8'h10);
    push(2'd0, 8'h20); send(8'h20);
    push(2'd0, 8'h30); send(8'h30);
    push(2'd1, 8'd0);  send(8'h60);
    idle(3);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL resync_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout;
    int err_at;
    err_at = -1;
    send("A");
    send("B");
    push(2'd0, 8'h01);
    send(8'h01);
    push(2'd2, 8'd2);
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      #1;
      if (frame_error === 1'b1 && err_at < 0) err_at = i;
    end
    tests++;
    if (err_at !== 20) begin
      fails++;
      $display("FAIL timeout_cycle got %0d want 20", err_at);
    end
    tests++;
    if (frame_active !== 1'b0 || error_code !== 2'd2) begin
      fails++;
      $display("FAIL timeout_state got active %b code %0d want 0 2",
               frame_active, error_code);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL timeout_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout_edge;
    send("A");
    send("C");
    idle(19);
    push(2'd0, 8'h07); send(8'h07);
    idle(19);
    push(2'd1, 8'd1);  send(8'h07);
    idle(3);
    tests++;
    if (frame_active !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL tmo_edge got active %b pending %0d want 0 0",
               frame_active, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midframe;
    send("A");
    send("B");
    push(2'd0, 8'h01);
    send(8'h01);
    reset = 1'b1;
    rx_data = 8'h02;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx_data_ready = 1'b0;
    tests++;
    if (frame_active !== 1'b0 || data_valid !== 1'b0 ||
        msg_out !== 8'h00) begin
      fails++;
      $display("FAIL midreset got active %b dv %b out %02h want 0 0 00",
               frame_active, data_valid, msg_out);
    end
    idle(2);
    send("A");
    send("C");
    push(2'd0, 8'h05); send(8'h05);
    push(2'd1, 8'd1);  send(8'h05);
    idle(3);
    tests++;
    if (msg_type !== 1'b1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL midreset_second got type %0d pending %0d want 1 0",
               msg_type, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    push(2'd0, 8'hA1);
    push(2'd0, 8'hB2);
    push(2'd0, 8'h03);
    push(2'd1, 8'd0);
    push(2'd0, 8'h09);
    push(2'd1, 8'd1);
    send("A");
    send("B");
    send(8'hA1);
    send(8'hB2);
    send(8'h03);
    send(8'h56);
    send("A");
    send("C");
    send(8'h09);
    send(8'h09);
    idle(3);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_checksum_err();
    test_resync();
    test_timeout();
    test_timeout_edge();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_frame_decoder.md
SERIAL_FRAME_DECODER -- requirements
Module: serial_frame_decoder

Interface
REQ-001 Parameter NUM_TYPES, default 2: number of frame types recognised, legal range 1..8.
REQ-002 Parameter HDR_LEN, default 5: header length in bytes, common to all types, legal range 1..8.
REQ-003 Parameter HEADERS, default {"ABCDE","FGHIJ"}: packed NUM_TYPES*HDR_LEN*8 bits; type k occupies bits [(k+1)*HDR_LEN*8-1 -: HDR_LEN*8], with the first byte received in the MSB.
REQ-004 Parameter PAYLOAD_LENS, default {16'd16,16'd8}: packed NUM_TYPES*16 bits; type k payload byte count is in bits [k*16 +: 16]; a count of 0 is legal.
REQ-005 Parameter CHECKSUM_EN, default 1: when 1, every frame ends with one checksum byte.
REQ-006 Parameter TIMEOUT_CYCLES, default 1000: maximum idle clocks allowed between bytes inside a frame, minimum 2.
REQ-007 clk  in  1  single clock; every register updates on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 rx_data  in  8  received byte; valid only in cycles where rx_data_ready=1.
REQ-010 rx_data_ready  in  1  one-cycle strobe; each high cycle delivers one byte.
REQ-011 msg_out  out  8  payload byte; holds its value until the next payload byte.
REQ-012 data_valid  out  1  one-cycle pulse marking msg_out as a new payload byte.
REQ-013 msg_type  out  TW=max(1,clog2(NUM_TYPES))  index of the matched type; stable while frame_active=1.
REQ-014 frame_active  out  1  high from header match until frame end.
REQ-015 frame_done  out  1  one-cycle pulse when a frame ends without error.
REQ-016 frame_error  out  1  one-cycle pulse when a frame is aborted.
REQ-017 error_code  out  2  error cause, valid with frame_error: 1=checksum, 2=timeout; otherwise holds its last value.

Function
REQ-018 The FSM SHALL have four states: IDLE, HEADER, PAYLOAD and CHECK.
REQ-019 IDLE: each strobed byte SHALL be compared with header byte 0 of every type, building a NUM_TYPES-bit candidate mask; if the mask is nonzero the FSM SHALL go to HEADER with index=1, otherwise stay in IDLE.
REQ-020 HEADER: each strobed byte SHALL be compared with header byte [index] of every type; the result SHALL be ANDed into the candidate mask and index incremented.
REQ-021 HEADER, mask becomes zero: the FSM SHALL return to IDLE and re-test the same byte as header byte 0 in the same cycle, so overlapping headers are not lost.
REQ-022 Header complete (index reaches HDR_LEN with mask nonzero): the lowest set bit of the mask SHALL give msg_type; the FSM SHALL set frame_active=1, load countdown=PAYLOAD_LENS[msg_type] and clear the checksum register.
REQ-023 HDR_LEN=1: the header SHALL complete on the IDLE byte itself.
REQ-024 PAYLOAD: each strobed byte SHALL appear on msg_out with data_valid=1 in the cycle after the strobe (latency 1); the byte SHALL be added into an 8-bit checksum (sum mod 256) and countdown decremented.
REQ-025 Zero-length payload: on header completion the FSM SHALL go directly to CHECK, or, if CHECKSUM_EN=0, end the frame.
REQ-026 When the last payload byte is consumed: go to CHECK if CHECKSUM_EN=1; otherwise end the frame.
REQ-027 CHECK: a strobed byte equal to the checksum SHALL end the frame; a byte that differs SHALL abort the frame with error_code=1.
REQ-028 Frame end: frame_done or frame_error SHALL pulse in the cycle after the last byte's strobe, frame_active SHALL drop in that same cycle, and the FSM SHALL return to IDLE.
REQ-029 Timeout counter: it SHALL be cleared by every strobe and otherwise increment in HEADER, PAYLOAD and CHECK; reaching TIMEOUT_CYCLES SHALL abort with error_code=2 (timeout in HEADER: pulse frame_error only, since frame_active is still 0).
REQ-030 Strobe in the same cycle the timeout would expire: the byte SHALL win and no timeout occurs.
REQ-031 Strobes SHALL be accepted every cycle with no back-pressure; the block SHALL never drop a byte.
REQ-032 Countdown and index counters SHALL be sized at 16 bits and clog2(HDR_LEN+1) bits respectively and SHALL never wrap.

Reset
REQ-033 While reset=1, the next edge SHALL force: state=IDLE, all counters and the mask=0, msg_out=0, msg_type=0, error_code=0, and every flag and pulse output=0.
REQ-034 Reset asserted mid-frame SHALL discard the frame with no frame_done or frame_error pulse; reset SHALL take priority over a simultaneous strobe.

Verification
REQ-035 All scenarios use NUM_TYPES=2, HDR_LEN=2, HEADERS={"AC","AB"}, PAYLOAD_LENS={1,3}, CHECKSUM_EN=1, TIMEOUT_CYCLES=20.
REQ-036 Stimulus "AB",01,02,03,06 -> msg_type=0; data_valid pulses three times carrying 01,02,03; frame_done pulses once.
REQ-037 Stimulus "AC",FF,FE -> msg_type=1; msg_out=FF; frame_error pulses with error_code=1.
REQ-038 Stimulus "AAB",10,20,30,60 -> header resynchronises on the second 'A'; the type-0 frame completes with frame_done.
REQ-039 Stimulus "AB",01 followed by 25 idle cycles -> frame_error pulses with error_code=2 exactly 20 cycles after the last strobe; frame_active=0 afterwards.
REQ-040 Stimulus "AB",01 then reset, then "AC",05,05 -> no pulse from the first frame; the second frame completes with msg_type=1.
